// File: rtl/cl_ocl_rr_arb.sv
// Two-requester round-robin AXI-Lite arbiter in front of one shared register slave.
// One transaction in flight at a time; completed transactions are counted per requester.
module cl_ocl_rr_arb #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_sync,

  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  input  logic [31:0]       s0_wdata,
  input  logic [3:0]        s0_wstrb,
  output logic              s0_bvalid,
  output logic [1:0]        s0_bresp,
  input  logic              s0_bready,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  output logic              s0_rvalid,
  output logic [31:0]       s0_rdata,
  output logic [1:0]        s0_rresp,
  input  logic              s0_rready,

  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  input  logic [31:0]       s1_wdata,
  input  logic [3:0]        s1_wstrb,
  output logic              s1_bvalid,
  output logic [1:0]        s1_bresp,
  input  logic              s1_bready,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  output logic              s1_rvalid,
  output logic [31:0]       s1_rdata,
  output logic [1:0]        s1_rresp,
  input  logic              s1_rready,

  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_rready,

  output logic [CNT_W-1:0]  txn_cnt0,
  output logic [CNT_W-1:0]  txn_cnt1,
  output logic              busy
);

  // state | meaning
  // IDLE  | sampling requests, accepts the granted one combinationally
  // M_WR  | presenting AW and W to the slave
  // M_B   | waiting for the slave write response
  // S_B   | forwarding write response to the granted requester
  // M_RD  | presenting AR to the slave
  // M_R   | waiting for the slave read data
  // S_R   | forwarding read data to the granted requester
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] M_WR = 3'd1;
  localparam logic [2:0] M_B  = 3'd2;
  localparam logic [2:0] S_B  = 3'd3;
  localparam logic [2:0] M_RD = 3'd4;
  localparam logic [2:0] M_R  = 3'd5;
  localparam logic [2:0] S_R  = 3'd6;

  logic [2:0]        r_state;
  logic              r_gnt;
  logic              r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_resp;
  logic [31:0]       r_rdata;
  logic              r_aw_done;
  logic              r_w_done;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic w_wr0, w_wr1, w_req0, w_req1;
  logic w_sel, w_sel_wr, w_idle_go, w_acc_wr, w_acc_rd;
  logic w_bv, w_rv, w_b_done, w_r_done, w_resp_done;

  assign w_wr0  = s0_awvalid & s0_wvalid;
  assign w_wr1  = s1_awvalid & s1_wvalid;
  assign w_req0 = w_wr0 | s0_arvalid;
  assign w_req1 = w_wr1 | s1_arvalid;

  // On a tie the port that did not win last time is chosen.
  assign w_sel     = (w_req0 & w_req1) ? ~r_last_gnt : w_req1;
  assign w_sel_wr  = w_sel ? w_wr1 : w_wr0;
  assign w_idle_go = (r_state == IDLE) & (w_req0 | w_req1) & ~rst_main_sync;
  assign w_acc_wr  = w_idle_go & w_sel_wr;
  assign w_acc_rd  = w_idle_go & ~w_sel_wr;

  assign s0_awready = w_acc_wr & ~w_sel;
  assign s0_wready  = w_acc_wr & ~w_sel;
  assign s0_arready = w_acc_rd & ~w_sel;
  assign s1_awready = w_acc_wr & w_sel;
  assign s1_wready  = w_acc_wr & w_sel;
  assign s1_arready = w_acc_rd & w_sel;

  assign m_awvalid = (r_state == M_WR) & ~r_aw_done;
  assign m_wvalid  = (r_state == M_WR) & ~r_w_done;
  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_bready  = (r_state == M_B);
  assign m_arvalid = (r_state == M_RD);
  assign m_rready  = (r_state == M_R);

  assign w_bv = (r_state == S_B);
  assign w_rv = (r_state == S_R);
  assign s0_bvalid = w_bv & ~r_gnt;
  assign s1_bvalid = w_bv & r_gnt;
  assign s0_rvalid = w_rv & ~r_gnt;
  assign s1_rvalid = w_rv & r_gnt;
  assign s0_bresp  = r_gnt ? 2'b00 : r_resp;
  assign s1_bresp  = r_gnt ? r_resp : 2'b00;
  assign s0_rresp  = r_gnt ? 2'b00 : r_resp;
  assign s1_rresp  = r_gnt ? r_resp : 2'b00;
  assign s0_rdata  = r_gnt ? 32'h0 : r_rdata;
  assign s1_rdata  = r_gnt ? r_rdata : 32'h0;

  assign w_b_done    = w_bv & (r_gnt ? s1_bready : s0_bready);
  assign w_r_done    = w_rv & (r_gnt ? s1_rready : s0_rready);
  assign w_resp_done = w_b_done | w_r_done;

  assign txn_cnt0 = r_cnt0;
  assign txn_cnt1 = r_cnt1;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_resp     <= '0;
      r_rdata    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_wr) begin
            r_gnt     <= w_sel;
            r_addr    <= w_sel ? s1_awaddr : s0_awaddr;
            r_wdata   <= w_sel ? s1_wdata : s0_wdata;
            r_wstrb   <= w_sel ? s1_wstrb : s0_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= M_WR;
          end else if (w_acc_rd) begin
            r_gnt   <= w_sel;
            r_addr  <= w_sel ? s1_araddr : s0_araddr;
            r_state <= M_RD;
          end
        end
        M_WR: begin
          // AW and W may complete in different cycles; leave once both have.
          if ((r_aw_done | m_awready) & (r_w_done | m_wready)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= M_B;
          end else begin
            if (m_awvalid & m_awready) r_aw_done <= 1'b1;
            if (m_wvalid & m_wready)   r_w_done  <= 1'b1;
          end
        end
        M_B: begin
          if (m_bvalid) begin
            r_resp  <= m_bresp;
            r_state <= S_B;
          end
        end
        M_RD: begin
          if (m_arready) r_state <= M_R;
        end
        M_R: begin
          if (m_rvalid) begin
            r_rdata <= m_rdata;
            r_resp  <= m_rresp;
            r_state <= S_R;
          end
        end
        S_B, S_R: begin
          if (w_resp_done) begin
            if (r_gnt) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else       r_cnt0 <= r_cnt0 + CNT_W'(1);
            r_last_gnt <= r_gnt;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_ocl_rr_arb.sv
// Directed bench for cl_ocl_rr_arb: drives both requesters and the shared slave by hand
// and checks every handshake against hand-computed values.
module tb_cl_ocl_rr_arb;
  logic        clk_main_a0 = 1'b0;
  logic        rst_main_sync;

  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_awaddr, s0_araddr, s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic [1:0]  s0_bresp, s0_rresp;

  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_awaddr, s1_araddr, s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic [1:0]  s1_bresp, s1_rresp;

  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  logic [15:0] txn_cnt0, txn_cnt1;
  logic        busy;

  int checks = 0;
  int failures = 0;

  cl_ocl_rr_arb #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_sync(rst_main_sync),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_bvalid(s0_bvalid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .txn_cnt0(txn_cnt0), .txn_cnt1(txn_cnt1), .busy(busy)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_main_sync = 1'b1;
    tick();
    tick();
    rst_main_sync = 1'b0;
    settle();
  endtask

  // From M_WR with a zero-wait slave: AW/W handshake, then B with the given resp. Ends in S_B.
  task automatic slave_write(input logic [1:0] resp);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    tick();
    m_awready = 1'b0;
    m_wready  = 1'b0;
    settle();
    chk("wr_m_bready", 32'(m_bready), 1);
    m_bvalid = 1'b1;
    m_bresp  = resp;
    tick();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    settle();
  endtask

  initial begin
    rst_main_sync = 1'b1;
    {s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready} = '0;
    {s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready} = '0;
    {s0_awaddr, s0_araddr, s0_wdata, s0_wstrb} = '0;
    {s1_awaddr, s1_araddr, s1_wdata, s1_wstrb} = '0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    {m_bresp, m_rresp, m_rdata} = '0;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_valids", {29'b0, m_awvalid, m_wvalid, m_arvalid}, 0);
    chk("rst_m_readies", {30'b0, m_bready, m_rready}, 0);
    chk("rst_s_valids", {28'b0, s0_bvalid, s0_rvalid, s1_bvalid, s1_rvalid}, 0);
    chk("rst_m_awaddr", m_awaddr, 0);
    chk("rst_cnt0", 32'(txn_cnt0), 0);
    chk("rst_cnt1", 32'(txn_cnt1), 0);

    // Single write on port 0
    s0_awvalid = 1'b1; s0_wvalid = 1'b1;
    s0_awaddr = 32'h500; s0_wdata = 32'hDEAD_BEEF; s0_wstrb = 4'hF;
    settle();
    chk("w1_s0_awready", 32'(s0_awready), 1);
    chk("w1_s0_wready", 32'(s0_wready), 1);
    chk("w1_s1_awready", 32'(s1_awready), 0);
    tick();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    settle();
    chk("w1_m_awvalid", 32'(m_awvalid), 1);
    chk("w1_m_wvalid", 32'(m_wvalid), 1);
    chk("w1_m_awaddr", m_awaddr, 32'h500);
    chk("w1_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("w1_m_wstrb", 32'(m_wstrb), 32'hF);
    chk("w1_busy", 32'(busy), 1);
    slave_write(2'b00);
    chk("w1_s0_bvalid", 32'(s0_bvalid), 1);
    chk("w1_s0_bresp", 32'(s0_bresp), 0);
    chk("w1_s1_outs", {26'b0, s1_bvalid, s1_rvalid, s1_bresp, s1_rresp}, 0);
    chk("w1_s1_rdata", s1_rdata, 0);
    chk("w1_cnt0_pre", 32'(txn_cnt0), 0);
    s0_bready = 1'b1;
    tick();
    s0_bready = 1'b0;
    settle();
    chk("w1_cnt0", 32'(txn_cnt0), 1);
    chk("w1_busy_end", 32'(busy), 0);
    chk("w1_s0_bvalid_end", 32'(s0_bvalid), 0);

    // Both ports hold a read: strict alternation starting with port 0
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = 32'h500;
    s1_arvalid = 1'b1; s1_araddr = 32'h504;
    settle();
    for (int i = 0; i < 6; i++) begin
      logic p;
      p = i[0];
      chk("rr_s0_arready", 32'(s0_arready), p ? 0 : 1);
      chk("rr_s1_arready", 32'(s1_arready), p ? 1 : 0);
      tick();
      chk("rr_m_arvalid", 32'(m_arvalid), 1);
      chk("rr_m_araddr", m_araddr, p ? 32'h504 : 32'h500);
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      settle();
      chk("rr_m_rready", 32'(m_rready), 1);
      m_rvalid = 1'b1; m_rdata = 32'h1000 + i; m_rresp = 2'b00;
      tick();
      m_rvalid = 1'b0; m_rdata = 32'h0;
      settle();
      chk("rr_s0_rvalid", 32'(s0_rvalid), p ? 0 : 1);
      chk("rr_s1_rvalid", 32'(s1_rvalid), p ? 1 : 0);
      chk("rr_rdata", p ? s1_rdata : s0_rdata, 32'h1000 + i);
      s0_rready = 1'b1; s1_rready = 1'b1;
      tick();
      s0_rready = 1'b0; s1_rready = 1'b0;
      settle();
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    settle();
    chk("rr_cnt0", 32'(txn_cnt0), 3);
    chk("rr_cnt1", 32'(txn_cnt1), 3);

    // Port 0 write and read in the same cycle: write first
    s0_awvalid = 1'b1; s0_wvalid = 1'b1; s0_awaddr = 32'h10; s0_wdata = 32'h1122_3344;
    s0_arvalid = 1'b1; s0_araddr = 32'h20;
    settle();
    chk("wr_first_awready", 32'(s0_awready), 1);
    chk("wr_first_arready", 32'(s0_arready), 0);
    tick();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    settle();
    chk("wr_first_m_awaddr", m_awaddr, 32'h10);
    chk("wr_first_m_arvalid", 32'(m_arvalid), 0);
    slave_write(2'b00);
    s0_bready = 1'b1;
    tick();
    s0_bready = 1'b0;
    settle();
    chk("rd_second_arready", 32'(s0_arready), 1);
    tick();
    s0_arvalid = 1'b0;
    settle();
    chk("rd_second_m_araddr", m_araddr, 32'h20);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    tick();
    m_rvalid = 1'b0;
    settle();
    chk("rd_second_rdata", s0_rdata, 32'h5555_AAAA);
    s0_rready = 1'b1;
    tick();
    s0_rready = 1'b0;
    settle();
    chk("wr_rd_cnt0", 32'(txn_cnt0), 5);

    // Port 1 write; slave delays AWREADY by 3 cycles, WREADY immediate
    s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_awaddr = 32'h40; s1_wdata = 32'hCAFE_0001; s1_wstrb = 4'h3;
    settle();
    chk("dly_s1_awready", 32'(s1_awready), 1);
    tick();
    s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_wready = 1'b1;
    settle();
    chk("dly_c1_awvalid", 32'(m_awvalid), 1);
    chk("dly_c1_wvalid", 32'(m_wvalid), 1);
    chk("dly_wstrb", 32'(m_wstrb), 32'h3);
    tick();
    m_wready = 1'b0;
    settle();
    chk("dly_c2_wvalid", 32'(m_wvalid), 0);
    chk("dly_c2_awvalid", 32'(m_awvalid), 1);
    tick();
    chk("dly_c3_awvalid", 32'(m_awvalid), 1);
    chk("dly_c3_bready", 32'(m_bready), 0);
    tick();
    chk("dly_c4_awvalid", 32'(m_awvalid), 1);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    settle();
    chk("dly_m_awvalid_done", 32'(m_awvalid), 0);
    chk("dly_m_bready", 32'(m_bready), 1);
    m_bvalid = 1'b1; m_bresp = 2'b01;
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    settle();
    chk("dly_s1_bvalid", 32'(s1_bvalid), 1);
    chk("dly_s1_bresp", 32'(s1_bresp), 1);
    chk("dly_s0_bvalid", 32'(s0_bvalid), 0);
    s1_bready = 1'b1;
    tick();
    settle();
    chk("dly_one_b", 32'(s1_bvalid), 0);
    tick();
    s1_bready = 1'b0;
    settle();
    chk("dly_still_one_b", 32'(s1_bvalid), 0);
    chk("dly_cnt1", 32'(txn_cnt1), 4);

    // Port 1 read with error resp; requester stalls rready for 5 cycles
    s1_arvalid = 1'b1; s1_araddr = 32'h80;
    settle();
    chk("stall_s1_arready", 32'(s1_arready), 1);
    tick();
    s1_arvalid = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAF_DEAD; m_rresp = 2'b10;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("stall_s1_rvalid", 32'(s1_rvalid), 1);
      chk("stall_s1_rdata", s1_rdata, 32'hDEAF_DEAD);
      chk("stall_s1_rresp", 32'(s1_rresp), 2);
      chk("stall_cnt1", 32'(txn_cnt1), 4);
      tick();
    end
    s1_rready = 1'b1;
    settle();
    chk("stall_last_rvalid", 32'(s1_rvalid), 1);
    tick();
    s1_rready = 1'b0;
    settle();
    chk("stall_rvalid_end", 32'(s1_rvalid), 0);
    chk("stall_cnt1_end", 32'(txn_cnt1), 5);

    // Reset during M_B, then a tie goes to port 0
    s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_awaddr = 32'h44;
    tick();
    s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    m_awready = 1'b0; m_wready = 1'b0;
    settle();
    chk("mb_bready", 32'(m_bready), 1);
    rst_main_sync = 1'b1;
    tick();
    chk("mbrst_busy", 32'(busy), 0);
    chk("mbrst_m_outs", {27'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("mbrst_s_outs", {28'b0, s0_bvalid, s0_rvalid, s1_bvalid, s1_rvalid}, 0);
    chk("mbrst_m_awaddr", m_awaddr, 0);
    chk("mbrst_cnt0", 32'(txn_cnt0), 0);
    chk("mbrst_cnt1", 32'(txn_cnt1), 0);
    rst_main_sync = 1'b0;
    tick();
    s0_arvalid = 1'b1; s0_araddr = 32'h500;
    s1_arvalid = 1'b1; s1_araddr = 32'h504;
    settle();
    chk("post_rst_tie_s0", 32'(s0_arready), 1);
    chk("post_rst_tie_s1", 32'(s1_arready), 0);
    tick();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    settle();
    chk("post_rst_araddr", m_araddr, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cl_ocl_rr_arb.md
# cl_ocl_rr_arb

Round-robin AXI-Lite arbiter that shares a single 32-bit AXI-Lite register slave between two AXI-Lite requesters. Examples are the PCIe AppPF BAR0 (OCL) path and a secondary management path (SDA or an internal sequencer). It sits between the OCL register slice outputs and the CL register decode. It serialises all traffic to one outstanding transaction at a time and counts completed transactions per requester for status readback.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports.
- CNT_W, 16, width of each per-requester transaction counter.

Ports:
- clk_main_a0  in  1  clock; everything is synchronous to its rising edge.
- rst_main_sync  in  1  reset; synchronous, active-high.
- s0_awvalid/s0_awready, s0_awaddr  in/out, in  1/1, ADDR_W  requester 0 write address.
- s0_wvalid/s0_wready, s0_wdata, s0_wstrb  in/out, in, in  1/1, 32, 4  requester 0 write data.
- s0_bvalid, s0_bresp, s0_bready  out, out, in  1, 2, 1  requester 0 write response.
- s0_arvalid/s0_arready, s0_araddr  in/out, in  1/1, ADDR_W  requester 0 read address.
- s0_rvalid, s0_rdata, s0_rresp, s0_rready  out, out, out, in  1, 32, 2, 1  requester 0 read data.
- s1_*  same set of signals for requester 1.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  master-side mirror of one s-port, driving the shared slave.
- txn_cnt0, txn_cnt1  out  CNT_W each  completed transactions per requester; wrap at 2^CNT_W.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Request per port: wr_req = awvalid && wvalid; rd_req = arvalid. Within a port, a write wins over a read when both are requesting.
- Round-robin pointer last_gnt resets to 1, so port 0 wins the first tie. When both ports request, the port != last_gnt is granted. When only one port requests, it is granted. last_gnt updates to the granted port when that transaction completes.
- FSM states: IDLE, M_WR, M_B, S_B, M_RD, M_R, S_R.
- IDLE, on grant of a write:
  - pulse awready and wready on the granted port together for 1 cycle.
  - latch addr, wdata and wstrb into internal registers.
  - go to M_WR.
- IDLE, on grant of a read: pulse arready for 1 cycle, latch araddr, go to M_RD.
- M_WR:
  - m_awvalid and m_wvalid are both driven high from the registers.
  - each valid drops independently after its own handshake; AW and W may complete in different cycles.
  - when both handshakes are done, go to M_B.
- M_B: m_bready = 1. On m_bvalid, latch bresp and go to S_B.
- S_B:
  - granted port bvalid = 1 with the latched bresp; hold until bready.
  - on the handshake: increment that port's counter, update last_gnt, go to IDLE.
- M_RD: m_arvalid = 1 until m_arready, then go to M_R.
- M_R: m_rready = 1. On m_rvalid, latch rdata and rresp, go to S_R.
- S_R: granted port rvalid = 1 until rready, then increment the counter, update last_gnt, go to IDLE.
- The non-granted port sees all ready/valid outputs at 0 for the whole transaction.
- wstrb, bresp and rresp pass through unmodified; the arbiter never generates an error response itself.

## Timing
- Reset values:
  - all s*/m* valid and ready outputs 0.
  - all data/addr/resp outputs 0.
  - txn_cnt0 = txn_cnt1 = 0, busy = 0, last_gnt = 1, state IDLE.
- Reset mid-transaction returns to IDLE immediately with the values above; the in-flight transaction is dropped.
- Grant and accept take 1 cycle. m_awvalid, m_wvalid and m_arvalid rise the cycle after the s-side accept.
- Response forwarding: s-side bvalid/rvalid rise the cycle after the m-side b/r handshake.
- Minimum write with a zero-wait slave: s accept @T, m AW/W handshake @T+1, m B handshake at the earliest @T+2, s bvalid @T+3. A new grant is possible the cycle after the s-side response handshake.
- m_bready and m_rready are high only in M_B and M_R respectively.
- IDLE samples requests every cycle. A request that arrives in the same cycle the FSM returns to IDLE is evaluated on the next cycle.
- A counter increment and a wrap from 2^CNT_W-1 to 0 happen in the response-handshake cycle.

## Test plan
- Single write on port 0, addr 0x500, data 0xDEAD_BEEF, slave bresp 0 -> m_awaddr 0x500 and m_wdata 0xDEAD_BEEF presented; s0_bvalid with bresp 0; txn_cnt0 = 1; s1 outputs stay 0.
- Both ports hold a read (0x500) continuously for 6 transactions -> grant order 0,1,0,1,0,1; txn_cnt0 = txn_cnt1 = 3.
- Port 0 presents a write and a read in the same cycle -> the write is served first, then the read (port 1 idle).
- Slave delays m_awready by 3 cycles while m_wready is immediate -> m_wvalid drops after 1 cycle, m_awvalid is held 4 cycles, and exactly one B is forwarded.
- Slave returns rresp 2'b10, rdata 0xDEAF_DEAD, and the requester holds rready low for 5 cycles -> s1_rvalid is held stable with that data and resp until rready.
- Assert rst_main_sync during M_B -> next cycle all outputs 0, busy 0; a subsequent port 1/port 0 tie grants port 0.
